// File: rtl/datapath_seq.sv
`default_nettype none
// ============================================================================
// Module      : datapath_seq
// Description : Multi-cycle register-file datapath (IDLE/RDA/RDB/EXEC/WB)
//               with shifter, 4-op ALU and Z/N/V/Cy status flags.
//               Optional macro DATAPATH_SEQ_CARRY_EN builds the carry flag.
// Revision    : 1.0 - initial release
// ============================================================================
module datapath_seq #(
    parameter int  DW   = 16,
    parameter int  NREG = 8,
    localparam int AW   = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_op,
    input  logic [1:0]    cmd_shift,
    input  logic [1:0]    cmd_vsel,
    input  logic          cmd_asel,
    input  logic          cmd_bsel,
    input  logic          cmd_wr,
    input  logic          cmd_loads,
    input  logic [AW-1:0] cmd_rd,
    input  logic [AW-1:0] cmd_rn,
    input  logic [AW-1:0] cmd_rm,
    input  logic [7:0]    cmd_imm,
    input  logic [DW-1:0] mdata,
    input  logic [7:0]    pc,
    output logic [DW-1:0] result,
    output logic [3:0]    status,
    output logic          done
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RDA  = 3'd1,
        S_RDB  = 3'd2,
        S_EXEC = 3'd3,
        S_WB   = 3'd4
    } state_t;

    typedef struct packed {
        logic [1:0]    op;
        logic [1:0]    shift;
        logic [1:0]    vsel;
        logic          asel;
        logic          bsel;
        logic          wr;
        logic          loads;
        logic [AW-1:0] rd;
        logic [AW-1:0] rn;
        logic [AW-1:0] rm;
        logic [7:0]    imm;
    } cmd_t;

    state_t        state_q, state_d;
    cmd_t          cmd_q, cmd_d;
    logic [DW-1:0] a_q, a_d, b_q, b_d, c_q, c_d;
    logic [3:0]    status_q, status_d;
    logic [DW-1:0] rf_q [NREG];
    logic [DW-1:0] rf_d [NREG];

    logic [DW-1:0] sximm5, sximm8, pc_ext;
    logic [DW-1:0] b_shift, ain, bin, alu_out, wb_val;
    logic          alu_v, alu_c;

    assign sximm5 = {{(DW-5){cmd_q.imm[4]}}, cmd_q.imm[4:0]};
    assign sximm8 = {{(DW-8){cmd_q.imm[7]}}, cmd_q.imm};
    assign pc_ext = {{(DW-8){1'b0}}, pc};

    always_comb begin
        b_shift = b_q;
        case (cmd_q.shift)
            2'b01:   b_shift = {b_q[DW-2:0], 1'b0};
            2'b10:   b_shift = {1'b0, b_q[DW-1:1]};
            2'b11:   b_shift = {b_q[DW-1], b_q[DW-1:1]};
            default: b_shift = b_q;
        endcase
    end

    assign ain = cmd_q.asel ? '0 : a_q;
    assign bin = cmd_q.bsel ? sximm5 : b_shift;

    always_comb begin
        alu_out = '0;
        alu_v   = 1'b0;
        case (cmd_q.op)
            2'b00: begin
                alu_out = ain + bin;
                alu_v   = (ain[DW-1] == bin[DW-1]) && (alu_out[DW-1] != ain[DW-1]);
            end
            2'b01: begin
                alu_out = ain - bin;
                alu_v   = (ain[DW-1] != bin[DW-1]) && (alu_out[DW-1] != ain[DW-1]);
            end
            2'b10:   alu_out = ain & bin;
            default: alu_out = ~bin;
        endcase
    end

`ifdef DATAPATH_SEQ_CARRY_EN
    // Add carry recovered from the MSB sum bit; sub reports no-borrow.
    always_comb begin
        alu_c = 1'b0;
        case (cmd_q.op)
            2'b00:   alu_c = (ain[DW-1] & bin[DW-1]) |
                             ((ain[DW-1] | bin[DW-1]) & ~alu_out[DW-1]);
            2'b01:   alu_c = (ain >= bin);
            default: alu_c = 1'b0;
        endcase
    end
`else
    assign alu_c = 1'b0;
`endif

    always_comb begin
        wb_val = c_q;
        case (cmd_q.vsel)
            2'b01:   wb_val = pc_ext;
            2'b10:   wb_val = sximm8;
            2'b11:   wb_val = mdata;
            default: wb_val = c_q;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cmd_d    = cmd_q;
        a_d      = a_q;
        b_d      = b_q;
        c_d      = c_q;
        status_d = status_q;
        rf_d     = rf_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    cmd_d.op    = cmd_op;
                    cmd_d.shift = cmd_shift;
                    cmd_d.vsel  = cmd_vsel;
                    cmd_d.asel  = cmd_asel;
                    cmd_d.bsel  = cmd_bsel;
                    cmd_d.wr    = cmd_wr;
                    cmd_d.loads = cmd_loads;
                    cmd_d.rd    = cmd_rd;
                    cmd_d.rn    = cmd_rn;
                    cmd_d.rm    = cmd_rm;
                    cmd_d.imm   = cmd_imm;
                    state_d     = (cmd_vsel == 2'b00) ? S_RDA : S_WB;
                end
            end
            S_RDA: begin
                a_d     = rf_q[cmd_q.rn];
                state_d = S_RDB;
            end
            S_RDB: begin
                b_d     = rf_q[cmd_q.rm];
                state_d = S_EXEC;
            end
            S_EXEC: begin
                c_d = alu_out;
                if (cmd_q.loads) begin
                    status_d = {(alu_out == '0), alu_out[DW-1], alu_v, alu_c};
                end
                state_d = S_WB;
            end
            S_WB: begin
                if (cmd_q.wr) begin
                    rf_d[cmd_q.rd] = wb_val;
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cmd_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            c_q      <= '0;
            status_q <= '0;
            for (int i = 0; i < NREG; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            cmd_q    <= cmd_d;
            a_q      <= a_d;
            b_q      <= b_d;
            c_q      <= c_d;
            status_q <= status_d;
            rf_q     <= rf_d;
        end
    end

    assign cmd_ready = (state_q == S_IDLE) && !reset;
    assign done      = (state_q == S_WB);
    assign result    = c_q;
    assign status    = status_q;

endmodule
`default_nettype wire

// File: tb/tb_datapath_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_datapath_seq
// Description : Randomized self-checking bench for datapath_seq against a
//               behavioural model; includes a DW=32/NREG=16 instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_datapath_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        cmd_valid, cmd_ready;
    logic [1:0]  cmd_op, cmd_shift, cmd_vsel;
    logic        cmd_asel, cmd_bsel, cmd_wr, cmd_loads;
    logic [2:0]  cmd_rd, cmd_rn, cmd_rm;
    logic [7:0]  cmd_imm, pc;
    logic [15:0] mdata, result;
    logic [3:0]  status;
    logic        done;

    logic        b_cmd_valid, b_cmd_ready;
    logic [1:0]  b_cmd_op, b_cmd_vsel;
    logic        b_cmd_wr, b_cmd_loads;
    logic [3:0]  b_cmd_rd, b_cmd_rn, b_cmd_rm;
    logic [7:0]  b_cmd_imm;
    logic [31:0] b_mdata, b_result;
    logic [3:0]  b_status;
    logic        b_done;

    datapath_seq #(.DW(16), .NREG(8)) u_dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_shift(cmd_shift), .cmd_vsel(cmd_vsel),
        .cmd_asel(cmd_asel), .cmd_bsel(cmd_bsel), .cmd_wr(cmd_wr), .cmd_loads(cmd_loads),
        .cmd_rd(cmd_rd), .cmd_rn(cmd_rn), .cmd_rm(cmd_rm), .cmd_imm(cmd_imm),
        .mdata(mdata), .pc(pc), .result(result), .status(status), .done(done)
    );

    datapath_seq #(.DW(32), .NREG(16)) u_dut32 (
        .clk(clk), .reset(reset), .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready),
        .cmd_op(b_cmd_op), .cmd_shift(2'b00), .cmd_vsel(b_cmd_vsel),
        .cmd_asel(1'b0), .cmd_bsel(1'b0), .cmd_wr(b_cmd_wr), .cmd_loads(b_cmd_loads),
        .cmd_rd(b_cmd_rd), .cmd_rn(b_cmd_rn), .cmd_rm(b_cmd_rm), .cmd_imm(b_cmd_imm),
        .mdata(b_mdata), .pc(8'h00), .result(b_result), .status(b_status), .done(b_done)
    );

    typedef struct {
        logic [1:0] op, shift, vsel;
        logic       asel, bsel, wr, loads;
        logic [2:0] rd, rn, rm;
        logic [7:0] imm;
    } cmd_t;

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] m_rf [8];
    logic [15:0] m_c;
    logic [3:0]  m_st;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Sign-extend the low 'bits' of v to a 16-bit pattern held in an int.
    function automatic int sx(input int v, input int bits);
        int m;
        int r;
        m = 1 << bits;
        r = v % m;
        if (r >= m / 2) return r + 65536 - m;
        return r;
    endfunction

    function automatic int to_s16(input int v);
        return (v >= 32768) ? v - 65536 : v;
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < 8; i++) m_rf[i] = 16'h0;
        m_c  = 16'h0;
        m_st = 4'h0;
    endfunction

    function automatic void model_apply(input cmd_t c, input logic [15:0] md, input logic [7:0] pcv);
        int a, b, sv, outv, cy, v, wb;
        wb = 0;
        if (c.vsel == 2'b00) begin
            a = c.asel ? 0 : int'(m_rf[c.rn]);
            b = int'(m_rf[c.rm]);
            case (c.shift)
                2'd1:    b = (b * 2) % 65536;
                2'd2:    b = b / 2;
                2'd3:    b = b / 2 + ((b >= 32768) ? 32768 : 0);
                default: b = b;
            endcase
            if (c.bsel) b = sx(int'(c.imm), 5);
            cy = 0;
            v  = 0;
            case (c.op)
                2'd0: begin
                    outv = (a + b) % 65536;
                    cy   = (a + b >= 65536) ? 1 : 0;
                    sv   = to_s16(a) + to_s16(b);
                    v    = (sv > 32767 || sv < -32768) ? 1 : 0;
                end
                2'd1: begin
                    outv = (a - b + 65536) % 65536;
                    cy   = (a >= b) ? 1 : 0;
                    sv   = to_s16(a) - to_s16(b);
                    v    = (sv > 32767 || sv < -32768) ? 1 : 0;
                end
                2'd2:    outv = a & b;
                default: outv = 65535 - b;
            endcase
`ifndef DATAPATH_SEQ_CARRY_EN
            cy = 0;
`endif
            m_c = outv[15:0];
            if (c.loads) m_st = {(outv == 0), (outv >= 32768), (v != 0), (cy != 0)};
            wb = outv;
        end else begin
            case (c.vsel)
                2'd1:    wb = int'(pcv);
                2'd2:    wb = sx(int'(c.imm), 8);
                default: wb = int'(md);
            endcase
        end
        if (c.wr) m_rf[c.rd] = wb[15:0];
    endfunction

    function automatic cmd_t mk_alu(input logic [1:0] op, input logic [1:0] shift,
                                    input logic asel, input logic bsel, input logic wr,
                                    input logic loads, input logic [2:0] rd,
                                    input logic [2:0] rn, input logic [2:0] rm,
                                    input logic [7:0] imm);
        cmd_t c;
        c.op = op; c.shift = shift; c.vsel = 2'b00; c.asel = asel; c.bsel = bsel;
        c.wr = wr; c.loads = loads; c.rd = rd; c.rn = rn; c.rm = rm; c.imm = imm;
        return c;
    endfunction

    function automatic cmd_t mk_mov(input logic [1:0] vsel, input logic [2:0] rd, input logic [7:0] imm);
        cmd_t c;
        c = mk_alu(2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, rd, 3'd0, 3'd0, imm);
        c.vsel = vsel;
        return c;
    endfunction

    // Read a register: C = 0 + reg[r], no write, flags untouched.
    function automatic cmd_t mk_rd(input logic [2:0] r);
        return mk_alu(2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, r, 8'h00);
    endfunction

    task automatic drive(input cmd_t c, input logic [15:0] md, input logic [7:0] pcv);
        cmd_op = c.op; cmd_shift = c.shift; cmd_vsel = c.vsel;
        cmd_asel = c.asel; cmd_bsel = c.bsel; cmd_wr = c.wr; cmd_loads = c.loads;
        cmd_rd = c.rd; cmd_rn = c.rn; cmd_rm = c.rm; cmd_imm = c.imm;
        mdata = md; pc = pcv;
    endtask

    task automatic scramble();
        cmd_op = 2'($urandom); cmd_shift = 2'($urandom); cmd_vsel = 2'($urandom);
        cmd_asel = 1'($urandom); cmd_bsel = 1'($urandom); cmd_wr = 1'($urandom);
        cmd_loads = 1'($urandom); cmd_rd = 3'($urandom); cmd_rn = 3'($urandom);
        cmd_rm = 3'($urandom); cmd_imm = 8'($urandom);
    endtask

    task automatic run_cmd(input cmd_t c, input logic [15:0] md, input logic [7:0] pcv, output int waited);
        int lat;
        drive(c, md, pcv);
        cmd_valid = 1'b1;
        waited = 0;
        while (!cmd_ready && waited < 20) begin
            @(posedge clk); #1; waited++;
        end
        if (!cmd_ready) begin
            check("accept_timeout", 32'(cmd_ready), 32'd1);
            cmd_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        scramble();
        lat = 1;
        while (!done && lat < 12) begin
            @(posedge clk); #1; lat++;
        end
        check("done_seen", 32'(done), 32'd1);
        check("latency", 32'(lat), (c.vsel == 2'b00) ? 32'd4 : 32'd1);
        model_apply(c, md, pcv);
        check("result", 32'(result), 32'(m_c));
        check("status", 32'(status), 32'(m_st));
        @(posedge clk); #1;
        check("done_pulse", 32'(done), 32'd0);
        check("ready_idle", 32'(cmd_ready), 32'd1);
        mdata = 16'($urandom);
        pc    = 8'($urandom);
    endtask

    task automatic b_run(input logic [1:0] op, input logic [1:0] vsel, input logic wr,
                         input logic loads, input logic [3:0] rd, input logic [3:0] rn,
                         input logic [3:0] rm, input logic [7:0] imm, input logic [31:0] md);
        int n;
        b_cmd_op = op; b_cmd_vsel = vsel; b_cmd_wr = wr; b_cmd_loads = loads;
        b_cmd_rd = rd; b_cmd_rn = rn; b_cmd_rm = rm; b_cmd_imm = imm; b_mdata = md;
        b_cmd_valid = 1'b1;
        n = 0;
        while (!b_cmd_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        @(posedge clk); #1;
        b_cmd_valid = 1'b0;
        n = 0;
        while (!b_done && n < 12) begin
            @(posedge clk); #1; n++;
        end
        check("b_done_seen", 32'(b_done), 32'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        int   w, n;
        cmd_t c, c2;
        logic [15:0] md;
        logic [7:0]  pcv;

        reset = 1'b0;
        cmd_valid = 1'b0;
        scramble();
        mdata = 16'h0; pc = 8'h0;
        b_cmd_valid = 1'b0; b_cmd_op = 2'b00; b_cmd_vsel = 2'b00; b_cmd_wr = 1'b0;
        b_cmd_loads = 1'b0; b_cmd_rd = 4'd0; b_cmd_rn = 4'd0; b_cmd_rm = 4'd0;
        b_cmd_imm = 8'h00; b_mdata = 32'h0;
        model_clear();

        #2 reset = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rst_result", 32'(result), 32'd0);
        check("rst_status", 32'(status), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_ready", 32'(cmd_ready), 32'd0);
        reset = 1'b0;
        #1;
        check("ready_after_release", 32'(cmd_ready), 32'd1);

        // Move of a negative 8-bit immediate.
        run_cmd(mk_mov(2'b10, 3'd1, 8'h80), 16'h0, 8'h0, w);
        run_cmd(mk_rd(3'd1), 16'h0, 8'h0, w);
        check("r1_sximm8", 32'(result), 32'h0000FF80);

        // Signed overflow on add.
        run_cmd(mk_mov(2'b11, 3'd1, 8'h00), 16'h7FFF, 8'h0, w);
        run_cmd(mk_mov(2'b10, 3'd2, 8'h01), 16'h0, 8'h0, w);
        run_cmd(mk_alu(2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 3'd3, 3'd1, 3'd2, 8'h00), 16'h0, 8'h0, w);
        check("add_ovf_result", 32'(result), 32'h00008000);
        check("add_ovf_status", 32'(status), 32'h6);

        // Subtract arithmetically shifted operand.
        run_cmd(mk_mov(2'b11, 3'd2, 8'h00), 16'h8002, 8'h0, w);
        run_cmd(mk_alu(2'b01, 2'b11, 1'b0, 1'b0, 1'b1, 1'b1, 3'd4, 3'd2, 3'd2, 8'h00), 16'h0, 8'h0, w);
        check("sub_asr_result", 32'(result), 32'h0000C001);
        check("sub_asr_status", 32'(status), 32'h4);

        // rd == rn == rm uses the pre-write operands.
        run_cmd(mk_mov(2'b11, 3'd5, 8'h00), 16'h1234, 8'h0, w);
        run_cmd(mk_alu(2'b01, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 3'd5, 3'd5, 3'd5, 8'h00), 16'h0, 8'h0, w);
`ifdef DATAPATH_SEQ_CARRY_EN
        check("sub_self_status", 32'(status), 32'h9);
`else
        check("sub_self_status", 32'(status), 32'h8);
`endif
        run_cmd(mk_rd(3'd5), 16'h0, 8'h0, w);
        check("r5_zero", 32'(result), 32'h0);

        // PC writeback and sximm5 on B with A forced to zero.
        run_cmd(mk_mov(2'b01, 3'd6, 8'h00), 16'h0, 8'hA5, w);
        run_cmd(mk_rd(3'd6), 16'h0, 8'h0, w);
        check("r6_pc", 32'(result), 32'h000000A5);
        run_cmd(mk_alu(2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1, 3'd0, 3'd3, 3'd3, 8'h10), 16'h0, 8'h0, w);
        check("sximm5_neg", 32'(result), 32'h0000FFF0);

        // Back-to-back acceptance with cmd_valid held high.
        c  = mk_rd(3'd1);
        c2 = mk_mov(2'b10, 3'd7, 8'h33);
        drive(c, 16'h0, 8'h0);
        cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (!cmd_ready && n < 20);
        check("b2b_alu_gap", 32'(n), 32'd5);
        model_apply(c, 16'h0, 8'h0);
        drive(c2, 16'h0, 8'h0);
        n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (!cmd_ready && n < 20);
        cmd_valid = 1'b0;
        check("b2b_mov_gap", 32'(n), 32'd2);
        model_apply(c2, 16'h0, 8'h0);
        run_cmd(mk_rd(3'd7), 16'h0, 8'h0, w);

        // Reset while in EXEC aborts the command.
        drive(mk_alu(2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 3'd6, 3'd1, 3'd2, 8'h00), 16'h0, 8'h0);
        cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        check("abort_result", 32'(result), 32'd0);
        check("abort_ready", 32'(cmd_ready), 32'd0);
        repeat (2) begin
            @(posedge clk); #1;
            check("abort_done", 32'(done), 32'd0);
        end
        reset = 1'b0;
        model_clear();
        #1;
        check("abort_ready_release", 32'(cmd_ready), 32'd1);
        run_cmd(mk_rd(3'd6), 16'h0, 8'h0, w);
        check("abort_accept_wait", 32'(w), 32'd0);
        run_cmd(mk_rd(3'd1), 16'h0, 8'h0, w);
        check("abort_r1_cleared", 32'(result), 32'd0);

        // Randomized commands against the model.
        for (int i = 0; i < 60; i++) begin
            c.op = 2'($urandom); c.shift = 2'($urandom); c.vsel = 2'($urandom);
            c.asel = 1'($urandom); c.bsel = 1'($urandom); c.wr = 1'($urandom_range(0, 3) != 0);
            c.loads = 1'($urandom); c.rd = 3'($urandom); c.rn = 3'($urandom);
            c.rm = 3'($urandom); c.imm = 8'($urandom);
            md  = 16'($urandom);
            pcv = 8'($urandom);
            run_cmd(c, md, pcv, w);
        end
        for (int r = 0; r < 8; r++) begin
            run_cmd(mk_rd(3'(r)), 16'h0, 8'h0, w);
        end

        // Wide instance: overflow at the 32-bit boundary.
        b_run(2'b00, 2'b11, 1'b1, 1'b0, 4'd1, 4'd0, 4'd0, 8'h00, 32'h7FFFFFFF);
        b_run(2'b00, 2'b10, 1'b1, 1'b0, 4'd2, 4'd0, 4'd0, 8'h01, 32'h0);
        b_run(2'b00, 2'b00, 1'b1, 1'b1, 4'd3, 4'd1, 4'd2, 8'h00, 32'h0);
        check("w32_add_result", b_result, 32'h80000000);
        check("w32_add_status", 32'(b_status), 32'h6);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
